sample_recorder: RTL and testbench

Writer side of the drum-sample memory. It captures a stream of incoming audio samples into sample RAM at sequential addresses 0..MAXCOUNT-1, using a ready/valid handshake on the input side and a single-cycle write strobe on the RAM side. Recording starts on a rec pulse and ends on a stop pulse or when memory is full. It reports the recorded length so the playback address counters know where a sample ends.

---
 rtl/sample_recorder_if.sv | 12 +
 rtl/sample_recorder.sv | 173 +++++++++++++++++
 tb/tb_sample_recorder.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sample_recorder_if.sv
// Ready/valid sample stream into the drum-sample recorder.
// The source drives valid/data; the recorder answers with ready.
interface sample_recorder_if #(
  parameter int DATA_W = 32
);
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic                     in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/sample_recorder.sv
// Writer side of the drum-sample RAM: records a sample stream at addresses 0..MAXCOUNT-1.
// Optional threshold-triggered start is enabled by defining SAMPLE_RECORDER_THRESH_START_EN.
module sample_recorder #(
  parameter int          DATA_W   = 32,
  parameter int          ADDR_W   = 18,
  parameter int          MAXCOUNT = 229120,
  parameter logic [31:0] THRESH   = 32'd4096
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     rec,
  input  logic                     stop,
  sample_recorder_if.slave         s_in,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic signed [DATA_W-1:0] wr_data,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_W:0]          length
);

`ifdef SAMPLE_RECORDER_THRESH_START_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    DONE   = 2'd2,
    ARM    = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    DONE   = 2'd2
  } state_t;
`endif

  state_t state, state_nxt;

  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [ADDR_W:0]          len_q, len_d;
  logic                     wr_en_d;
  logic [ADDR_W-1:0]        wr_addr_d;
  logic                     ready;
  logic                     accept;
  logic                     last;

  logic                     wr_en_p1;
  logic [ADDR_W-1:0]        wr_addr_p1;
  logic signed [DATA_W-1:0] wr_data_p1;

`ifdef SAMPLE_RECORDER_THRESH_START_EN
  localparam int MW = (DATA_W > 32) ? DATA_W : 32;

  // |x| with the most negative code saturated to the largest positive code.
  function automatic logic [DATA_W-1:0] sat_abs(input logic signed [DATA_W-1:0] x);
    logic [DATA_W-1:0] most_neg;
    most_neg = {1'b1, {(DATA_W-1){1'b0}}};
    if (!x[DATA_W-1])
      return x;
    else if (x == most_neg)
      return {1'b0, {(DATA_W-1){1'b1}}};
    else
      return -x;
  endfunction

  logic hit;
  assign hit   = (MW'(sat_abs(s_in.in_data)) >= MW'(THRESH));
  assign ready = (state == RECORD) || (state == ARM);
`else
  logic unused_thresh;
  assign unused_thresh = ^THRESH;
  assign ready = (state == RECORD);
`endif

  assign s_in.in_ready = ready;
  assign accept        = s_in.in_valid && ready;
  assign last          = (addr_q == ADDR_W'(MAXCOUNT - 1));
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    addr_d    = addr_q;
    len_d     = len_q;
    wr_en_d   = 1'b0;
    wr_addr_d = addr_q;
    case (state)
      IDLE: begin
        if (rec) begin
          addr_d = '0;
`ifdef SAMPLE_RECORDER_THRESH_START_EN
          state_nxt = ARM;
`else
          state_nxt = RECORD;
`endif
        end
      end
`ifdef SAMPLE_RECORDER_THRESH_START_EN
      ARM: begin
        // stop wins over a same-cycle trigger: the recording ends empty
        if (stop) begin
          len_d     = '0;
          state_nxt = DONE;
        end else if (accept && hit) begin
          wr_en_d   = 1'b1;
          wr_addr_d = '0;
          if (MAXCOUNT == 1) begin
            len_d     = (ADDR_W+1)'(1);
            state_nxt = DONE;
          end else begin
            addr_d    = ADDR_W'(1);
            state_nxt = RECORD;
          end
        end
      end
`endif
      RECORD: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          if (!last)
            addr_d = addr_q + ADDR_W'(1);
        end
        // The count includes a sample taken in the ending cycle; on a full
        // accept this equals MAXCOUNT whether or not stop is also high.
        if ((accept && last) || stop) begin
          len_d     = {1'b0, addr_q} + (ADDR_W+1)'(accept);
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q <= '0;
      len_q  <= '0;
    end else begin
      addr_q <= addr_d;
      len_q  <= len_d;
    end
  end

  // stage p1: registered RAM write port, one cycle after the accept
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_en_p1   <= 1'b0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
    end else begin
      wr_en_p1 <= wr_en_d;
      if (wr_en_d) begin
        wr_addr_p1 <= wr_addr_d;
        wr_data_p1 <= s_in.in_data;
      end
    end
  end

  assign wr_en   = wr_en_p1;
  assign wr_addr = wr_addr_p1;
  assign wr_data = wr_data_p1;
  assign length  = len_q;

endmodule

// File: tb/tb_sample_recorder.sv
// Self-checking bench for sample_recorder against a behavioural recording model.
module tb_sample_recorder;
  localparam int          DW   = 32;
  localparam int          AW   = 4;
  localparam int          MAXC = 8;
  localparam logic [31:0] TH   = 32'd100;
`ifdef SAMPLE_RECORDER_THRESH_START_EN
  localparam bit TEN  = 1'b1;
  localparam int DOFS = 1000;
`else
  localparam bit TEN  = 1'b0;
  localparam int DOFS = 0;
`endif
  localparam int P_IDLE = 0, P_ARM = 1, P_REC = 2, P_DONE = 3;

  logic clk = 1'b0, resetn = 1'b0, rec = 1'b0, stop = 1'b0;
  logic                 wr_en, busy, done;
  logic [AW-1:0]        wr_addr;
  logic signed [DW-1:0] wr_data;
  logic [AW:0]          length;

  sample_recorder_if #(.DATA_W(DW)) bus ();

  sample_recorder #(.DATA_W(DW), .ADDR_W(AW), .MAXCOUNT(MAXC), .THRESH(TH)) dut (
    .clk(clk), .resetn(resetn), .rec(rec), .stop(stop), .s_in(bus),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .length(length)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int m_phase, m_n, m_len, m_done;
  int exp_wa[$], obs_wa[$];
  logic [31:0] exp_wd[$], obs_wd[$];
  int obs_done;

  always @(negedge clk) begin
    if (resetn) begin
      if (wr_en) begin
        obs_wa.push_back(int'(wr_addr));
        obs_wd.push_back(wr_data);
      end
      if (done) obs_done++;
    end
  end

  task automatic model_reset();
    m_phase = P_IDLE; m_n = 0; m_len = 0;
  endtask

  task automatic clear_logs();
    exp_wa.delete(); exp_wd.delete(); obs_wa.delete(); obs_wd.delete();
    obs_done = 0; m_done = 0;
  endtask

  task automatic finish_rec(input int len);
    m_len = len; m_phase = P_DONE; m_done++;
  endtask

  // Recording rules: what gets stored where, and when the take ends.
  task automatic model_step(input bit r, input bit s, input bit v, input logic [31:0] d);
    bit acc;
    longint sv, mag;
    acc = v && (m_phase == P_ARM || m_phase == P_REC);
    sv  = longint'($signed(d));
    mag = (sv < 0) ? -sv : sv;
    if (mag > 64'sd2147483647) mag = 64'sd2147483647;
    case (m_phase)
      P_IDLE: if (r) begin m_n = 0; m_phase = TEN ? P_ARM : P_REC; end
      P_ARM: begin
        if (s) finish_rec(0);
        else if (acc && mag >= longint'(TH)) begin
          exp_wa.push_back(0); exp_wd.push_back(d); m_n = 1;
          if (m_n == MAXC) finish_rec(MAXC); else m_phase = P_REC;
        end
      end
      P_REC: begin
        if (acc) begin exp_wa.push_back(m_n); exp_wd.push_back(d); m_n++; end
        if (m_n == MAXC) finish_rec(MAXC);
        else if (s) finish_rec(m_n);
      end
      default: m_phase = P_IDLE;
    endcase
  endtask

  task automatic step(input bit r, input bit s, input bit v, input logic [31:0] d);
    @(negedge clk);
    rec = r; stop = s; bus.in_valid = v; bus.in_data = d;
    model_step(r, s, v, d);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({wr_en, busy, done, bus.in_ready} !== 4'b0 || wr_addr !== '0 || wr_data !== '0 || length !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got en=%b busy=%b done=%b rdy=%b addr=%0d data=%0d len=%0d, required all 0",
               wr_en, busy, done, bus.in_ready, wr_addr, wr_data, length);
    end
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
    clear_logs();
  endtask

  task automatic test_basic();
    clear_logs();
    step(1'b1, 1'b0, 1'b0, 32'd0);
    for (int i = 1; i <= 5; i++) step(1'b0, 1'b0, 1'b1, 32'(DOFS + i));
    step(1'b0, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (done !== (m_phase == P_DONE) || busy !== (m_phase != P_IDLE) || bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_done_busy[%0d]: got done=%b busy=%b rdy=%b, required done=%b busy=%b rdy=0",
                 i, done, busy, bus.in_ready, m_phase == P_DONE, m_phase != P_IDLE);
      end
      step(1'b0, 1'b0, 1'b0, 32'd0);
    end
    n_checks++;
    if (obs_wa.size() != exp_wa.size() || obs_done != m_done || length !== (AW+1)'(m_len)) begin
      n_fail++;
      $display("FAIL basic_summary: got writes=%0d done=%0d len=%0d, required writes=%0d done=%0d len=%0d",
               obs_wa.size(), obs_done, length, exp_wa.size(), m_done, m_len);
    end
    foreach (exp_wa[i]) if (i < obs_wa.size()) begin
      n_checks++;
      if (obs_wa[i] != exp_wa[i] || obs_wd[i] !== exp_wd[i]) begin
        n_fail++;
        $display("FAIL basic_write[%0d]: got addr=%0d data=%0d, required addr=%0d data=%0d",
                 i, obs_wa[i], obs_wd[i], exp_wa[i], exp_wd[i]);
      end
    end
  endtask

  task automatic test_full();
    clear_logs();
    step(1'b1, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < MAXC + 4; i++) step(1'b0, 1'b0, 1'b1, 32'(DOFS + $urandom_range(0, 999)));
    n_checks++;
    if (bus.in_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL full_after: got rdy=%b busy=%b, required 0 0", bus.in_ready, busy);
    end
    idle(2);
    n_checks++;
    if (obs_wa.size() != exp_wa.size() || obs_done != m_done || length !== (AW+1)'(m_len)) begin
      n_fail++;
      $display("FAIL full_summary: got writes=%0d done=%0d len=%0d, required writes=%0d done=%0d len=%0d",
               obs_wa.size(), obs_done, length, exp_wa.size(), m_done, m_len);
    end
    foreach (exp_wa[i]) if (i < obs_wa.size()) begin
      n_checks++;
      if (obs_wa[i] != exp_wa[i] || obs_wd[i] !== exp_wd[i]) begin
        n_fail++;
        $display("FAIL full_write[%0d]: got addr=%0d data=%0d, required addr=%0d data=%0d",
                 i, obs_wa[i], obs_wd[i], exp_wa[i], exp_wd[i]);
      end
    end
  endtask

  // Gapped valid, stop with a sample, empty take, and rec ignored mid-stream.
  task automatic test_stop_cases();
    clear_logs();
    step(1'b1, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, i % 2 == 0, 32'(DOFS + 10 + i));
    step(1'b0, 1'b1, 1'b0, 32'd0);
    idle(2);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b1, 32'(DOFS + 21));
    step(1'b0, 1'b0, 1'b1, 32'(DOFS + 22));
    step(1'b0, 1'b1, 1'b1, 32'(DOFS + 23));
    idle(2);
    n_checks++;
    if (length !== (AW+1)'(m_len)) begin
      n_fail++;
      $display("FAIL stop_with_sample_len: got %0d, required %0d", length, m_len);
    end
    step(1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    idle(2);
    n_checks++;
    if (length !== (AW+1)'(m_len)) begin
      n_fail++;
      $display("FAIL stop_empty_len: got %0d, required %0d", length, m_len);
    end
    step(1'b1, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 32'(DOFS + 40 + i));
    step(1'b1, 1'b0, 1'b1, 32'(DOFS + 44));
    step(1'b0, 1'b0, 1'b1, 32'(DOFS + 45));
    step(1'b0, 1'b1, 1'b0, 32'd0);
    idle(2);
    n_checks++;
    if (obs_wa.size() != exp_wa.size() || obs_done != m_done || length !== (AW+1)'(m_len)) begin
      n_fail++;
      $display("FAIL stop_summary: got writes=%0d done=%0d len=%0d, required writes=%0d done=%0d len=%0d",
               obs_wa.size(), obs_done, length, exp_wa.size(), m_done, m_len);
    end
    foreach (exp_wa[i]) if (i < obs_wa.size()) begin
      n_checks++;
      if (obs_wa[i] != exp_wa[i] || obs_wd[i] !== exp_wd[i]) begin
        n_fail++;
        $display("FAIL stop_write[%0d]: got addr=%0d data=%0d, required addr=%0d data=%0d",
                 i, obs_wa[i], obs_wd[i], exp_wa[i], exp_wd[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    step(1'b1, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 32'(DOFS + 60 + i));
    @(negedge clk);
    bus.in_valid = 1'b0; rec = 1'b0;
    #2 resetn = 1'b0;
    #1;
    n_checks++;
    if ({wr_en, busy, done, bus.in_ready} !== 4'b0 || wr_addr !== '0 || wr_data !== '0 || length !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got en=%b busy=%b done=%b rdy=%b addr=%0d data=%0d len=%0d, required all 0",
               wr_en, busy, done, bus.in_ready, wr_addr, wr_data, length);
    end
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
    clear_logs();
    step(1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b1, 32'(DOFS + 70));
    step(1'b0, 1'b0, 1'b1, 32'(DOFS + 71));
    step(1'b0, 1'b1, 1'b0, 32'd0);
    idle(2);
    n_checks++;
    if (obs_wa.size() != exp_wa.size() || obs_done != m_done || length !== (AW+1)'(m_len)) begin
      n_fail++;
      $display("FAIL reset_mid_summary: got writes=%0d done=%0d len=%0d, required writes=%0d done=%0d len=%0d",
               obs_wa.size(), obs_done, length, exp_wa.size(), m_done, m_len);
    end
    foreach (exp_wa[i]) if (i < obs_wa.size()) begin
      n_checks++;
      if (obs_wa[i] != exp_wa[i] || obs_wd[i] !== exp_wd[i]) begin
        n_fail++;
        $display("FAIL reset_mid_write[%0d]: got addr=%0d data=%0d, required addr=%0d data=%0d",
                 i, obs_wa[i], obs_wd[i], exp_wa[i], exp_wd[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_logs();
    step(1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b1, 32'(DOFS + 80));
    step(1'b0, 1'b1, 1'b1, 32'(DOFS + 81));
    step(1'b1, 1'b0, 1'b0, 32'd0);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_rec_in_done: got busy=%b, required 0", busy);
    end
    step(1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b1, 32'(DOFS + 90));
    step(1'b0, 1'b1, 1'b0, 32'd0);
    idle(2);
    n_checks++;
    if (obs_wa.size() != exp_wa.size() || obs_done != m_done || length !== (AW+1)'(m_len)) begin
      n_fail++;
      $display("FAIL b2b_summary: got writes=%0d done=%0d len=%0d, required writes=%0d done=%0d len=%0d",
               obs_wa.size(), obs_done, length, exp_wa.size(), m_done, m_len);
    end
    foreach (exp_wa[i]) if (i < obs_wa.size()) begin
      n_checks++;
      if (obs_wa[i] != exp_wa[i] || obs_wd[i] !== exp_wd[i]) begin
        n_fail++;
        $display("FAIL b2b_write[%0d]: got addr=%0d data=%0d, required addr=%0d data=%0d",
                 i, obs_wa[i], obs_wd[i], exp_wa[i], exp_wd[i]);
      end
    end
  endtask

`ifdef SAMPLE_RECORDER_THRESH_START_EN
  task automatic test_thresh();
    logic [31:0] seq [4];
    seq[0] = 32'd10; seq[1] = -32'sd50; seq[2] = -32'sd150; seq[3] = 32'd20;
    clear_logs();
    step(1'b1, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, seq[i]);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    idle(2);
    n_checks++;
    if (obs_wa.size() != 2 || length !== (AW+1)'(2)) begin
      n_fail++;
      $display("FAIL thresh_count: got writes=%0d len=%0d, required 2 2", obs_wa.size(), length);
    end else begin
      n_checks++;
      if (obs_wa[0] != 0 || obs_wd[0] !== -32'sd150 || obs_wa[1] != 1 || obs_wd[1] !== 32'd20) begin
        n_fail++;
        $display("FAIL thresh_writes: got (%0d,%0d) (%0d,%0d), required (0,-150) (1,20)",
                 obs_wa[0], $signed(obs_wd[0]), obs_wa[1], $signed(obs_wd[1]));
      end
    end
  endtask
`endif

  task automatic test_random();
    logic [31:0] d;
    clear_logs();
    for (int i = 0; i < 600; i++) begin
      d = ($urandom_range(0, 3) == 0) ? 32'($signed($urandom_range(0, 400)) - 200) : $urandom;
      step($urandom_range(0, 15) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1, d);
      n_checks++;
      if (busy !== (m_phase != P_IDLE) || done !== (m_phase == P_DONE) ||
          bus.in_ready !== (m_phase == P_ARM || m_phase == P_REC)) begin
        n_fail++;
        $display("FAIL random_ctrl[%0d]: got busy=%b done=%b rdy=%b, model phase %0d", i, busy, done, bus.in_ready, m_phase);
      end
    end
    step(1'b0, 1'b1, 1'b0, 32'd0);
    idle(3);
    n_checks++;
    if (obs_wa.size() != exp_wa.size() || obs_done != m_done || length !== (AW+1)'(m_len)) begin
      n_fail++;
      $display("FAIL random_summary: got writes=%0d done=%0d len=%0d, required writes=%0d done=%0d len=%0d",
               obs_wa.size(), obs_done, length, exp_wa.size(), m_done, m_len);
    end
    foreach (exp_wa[i]) if (i < obs_wa.size()) begin
      n_checks++;
      if (obs_wa[i] != exp_wa[i] || obs_wd[i] !== exp_wd[i]) begin
        n_fail++;
        $display("FAIL random_write[%0d]: got addr=%0d data=%0d, required addr=%0d data=%0d",
                 i, obs_wa[i], obs_wd[i], exp_wa[i], exp_wd[i]);
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    model_reset();
    clear_logs();
    test_reset();
    test_basic();
    test_full();
    test_stop_cases();
    test_reset_mid();
    test_back_to_back();
`ifdef SAMPLE_RECORDER_THRESH_START_EN
    test_thresh();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
